// File: rtl/datagram_tx_scheduler_pkg.sv
// Shared types and helpers for the datagram transmit scheduler.
// State encoding, default frame constants and small byte arithmetic helpers.
package datagram_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        PAYLOAD  = 2'd2,
        CHECKSUM = 2'd3
    } tx_state_e;

    localparam int         DEF_MSG_BYTES = 64;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Two's-complement negation: payload sum plus this value wraps to zero.
    function automatic logic [7:0] neg8(input logic [7:0] v);
        return (~v) + 8'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/datagram_tx_scheduler_snapshot.sv
// Frozen copy of the outgoing datagram with a byte-select read port.
// The copy only changes on load_i, so upstream edits never leak into a frame.
module datagram_snapshot #(
    parameter int MSG_BYTES = 64,
    parameter int CNT_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [MSG_BYTES*8-1:0] data_i,
    input  logic [CNT_W-1:0]       idx_i,
    output logic [7:0]             byte_o
);

    logic [MSG_BYTES*8-1:0] snap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
        end else if (load_i) begin
            snap_q <= data_i;
        end
    end

    // Out-of-range indices (non power-of-two lengths) read as zero.
    always_comb begin
        byte_o = 8'h00;
        for (int k = 0; k < MSG_BYTES; k++) begin
            if (idx_i == CNT_W'(k)) begin
                byte_o = snap_q[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/datagram_tx_scheduler.sv
// Frames the control core's datagram as SYNC, payload bytes, checksum and
// feeds it byte by byte to the UART transmitter over a valid/ready handshake.
module datagram_tx_scheduler
    import datagram_tx_scheduler_pkg::*;
#(
    parameter int         MSG_BYTES = DEF_MSG_BYTES,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int         CNT_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   frame_tick,
    input  logic [MSG_BYTES*8-1:0] datagram,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   frame_sent,
    output logic [7:0]             dropped_count
);

    tx_state_e        state_q;
    logic [CNT_W-1:0] idx_q;
    logic [7:0]       acc_q;
    logic             pending_q;
    logic [7:0]       drop_q;
    logic             tx_valid_q;
    logic [7:0]       tx_data_q;

    logic             xfer;
    logic             last_idx;
    logic             capture;
    logic [CNT_W-1:0] rd_idx;
    logic [7:0]       acc_d;
    logic [7:0]       snap_byte;

    always_comb begin
        xfer     = tx_valid_q & tx_ready;
        last_idx = (idx_q == CNT_W'(MSG_BYTES - 1));
        capture  = en & (((state_q == IDLE) & (frame_tick | pending_q)) |
                         ((state_q == CHECKSUM) & xfer & pending_q));
        // tx_data is registered, so the mux looks one byte ahead of idx_q.
        rd_idx   = (state_q == PAYLOAD) ? idx_q + CNT_W'(1) : '0;
        acc_d    = acc_q + tx_data_q;
    end

    datagram_snapshot #(
        .MSG_BYTES (MSG_BYTES),
        .CNT_W     (CNT_W)
    ) u_snapshot (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (capture),
        .data_i (datagram),
        .idx_i  (rd_idx),
        .byte_o (snap_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= 8'h00;
            pending_q  <= 1'b0;
            drop_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            // A tick while busy (including the checksum transfer cycle) is
            // parked once; anything beyond that is counted as dropped.
            if (en && (state_q != IDLE) && frame_tick) begin
                if (pending_q) begin
                    drop_q <= sat_inc8(drop_q);
                end else begin
                    pending_q <= 1'b1;
                end
            end
            if (!en || capture) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q    <= SYNC;
                        idx_q      <= '0;
                        acc_q      <= 8'h00;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                    end
                end
                SYNC: begin
                    if (xfer) begin
                        state_q   <= PAYLOAD;
                        idx_q     <= '0;
                        tx_data_q <= snap_byte;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        acc_q <= acc_d;
                        if (last_idx) begin
                            state_q   <= CHECKSUM;
                            tx_data_q <= neg8(acc_d);
                        end else begin
                            idx_q     <= idx_q + CNT_W'(1);
                            tx_data_q <= snap_byte;
                        end
                    end
                end
                CHECKSUM: begin
                    if (xfer) begin
                        if (capture) begin
                            state_q   <= SYNC;
                            idx_q     <= '0;
                            acc_q     <= 8'h00;
                            tx_data_q <= SYNC_BYTE;
                        end else begin
                            state_q    <= IDLE;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= 8'h00;
                end
            endcase
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != IDLE);
    assign frame_sent    = (state_q == CHECKSUM) & xfer;
    assign dropped_count = drop_q;

endmodule
